// File: rtl/pipelined_comparator_if.sv
// Operand/result bundle for the pipelined comparator.
// The master drives operands and controls; the slave returns results.
interface pipelined_comparator_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 16
);
    logic             in_valid;
    logic [2:0]       mode;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic             stall;
    logic             flush;
    logic             clear_count;
    logic             Z;
    logic             out_valid;
    logic [CW-1:0]    hit_count;

    modport master (
        output in_valid, mode, D1, D2,
        output stall, flush, clear_count,
        input  Z, out_valid, hit_count
    );

    modport slave (
        input  in_valid, mode, D1, D2,
        input  stall, flush, clear_count,
        output Z, out_valid, hit_count
    );
endinterface

// File: rtl/pipelined_comparator.sv
// Two-stage EQ/NE/LT/LTU/GE/GEU comparator with stall, flush
// and a saturating count of true results.
module pipelined_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int CW    = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipelined_comparator_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;

    localparam logic [2:0] M_EQ  = 3'b000;
    localparam logic [2:0] M_NE  = 3'b001;
    localparam logic [2:0] M_LT  = 3'b010;
    localparam logic [2:0] M_LTU = 3'b011;
    localparam logic [2:0] M_GE  = 3'b100;
    localparam logic [2:0] M_GEU = 3'b101;

    logic [NCH-1:0] w_eq_chunk;
    logic           w_ltu_in;
    logic           w_adv;

    logic           r_s1_valid;
    logic [2:0]     r_s1_mode;
    logic [NCH-1:0] r_s1_eq;
    logic           r_s1_ltu;
    logic           r_s1_sa;
    logic           r_s1_sb;

    logic           w_eq;
    logic           w_lts;
    logic           w_z;
    logic           w_hit;

    logic           r_z;
    logic           r_out_valid;
    logic [CW-1:0]  r_hit;

    // Per-chunk equality of the raw operands
    always_comb begin
        w_eq_chunk = '0;
        for (int i = 0; i < NCH; i++) begin
            w_eq_chunk[i] = (bus.D1[i*CHUNK +: CHUNK] ==
                             bus.D2[i*CHUNK +: CHUNK]);
        end
    end

    assign w_ltu_in = (bus.D1 < bus.D2);
    assign w_adv    = !bus.flush && !bus.stall;

    // Stage 1: capture partial compare flags and sign bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 3'b000;
            r_s1_eq    <= '0;
            r_s1_ltu   <= 1'b0;
            r_s1_sa    <= 1'b0;
            r_s1_sb    <= 1'b0;
        end else if (bus.flush) begin
            r_s1_valid <= 1'b0;
        end else if (!bus.stall) begin
            r_s1_valid <= bus.in_valid;
            r_s1_mode  <= bus.mode;
            r_s1_eq    <= w_eq_chunk;
            r_s1_ltu   <= w_ltu_in;
            r_s1_sa    <= bus.D1[WIDTH-1];
            r_s1_sb    <= bus.D2[WIDTH-1];
        end
    end

    // Stage 2 combine: full equality, signed less-than, mode select
    always_comb begin
        w_eq  = &r_s1_eq;
        w_lts = (r_s1_sa == r_s1_sb) ? r_s1_ltu : r_s1_sa;
        unique case (r_s1_mode)
            M_EQ:    w_z = w_eq;
            M_NE:    w_z = !w_eq;
            M_LT:    w_z = w_lts;
            M_LTU:   w_z = r_s1_ltu;
            M_GE:    w_z = !w_lts;
            M_GEU:   w_z = !r_s1_ltu;
            default: w_z = 1'b0;
        endcase
        w_hit = r_s1_valid && w_z;
    end

    // Stage 2 register: Z is forced low for invalid slots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_z         <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_z         <= 1'b0;
        end else if (!bus.stall) begin
            r_out_valid <= r_s1_valid;
            r_z         <= w_hit;
        end
    end

    // Saturating hit counter; clear beats stall and increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit <= '0;
        end else if (bus.clear_count) begin
            r_hit <= '0;
        end else if (w_adv && w_hit && (r_hit != '1)) begin
            r_hit <= r_hit + 1'b1;
        end
    end

    assign bus.Z         = r_z;
    assign bus.out_valid = r_out_valid;
    assign bus.hit_count = r_hit;
endmodule

// File: tb/tb_pipelined_comparator.sv
// Directed bench for pipelined_comparator: two instances (CW=16, CW=4)
// share stimulus and are checked against a behavioural reference.
module tb_pipelined_comparator;
    localparam logic [2:0] EQ  = 3'b000;
    localparam logic [2:0] NE  = 3'b001;
    localparam logic [2:0] LT  = 3'b010;
    localparam logic [2:0] LTU = 3'b011;
    localparam logic [2:0] GE  = 3'b100;
    localparam logic [2:0] GEU = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_comparator_if #(.WIDTH(32), .CW(16)) b16 ();
    pipelined_comparator_if #(.WIDTH(32), .CW(4))  b4 ();

    assign b16.in_valid    = in_valid;
    assign b16.mode        = mode;
    assign b16.D1          = d1;
    assign b16.D2          = d2;
    assign b16.stall       = stall;
    assign b16.flush       = flush;
    assign b16.clear_count = clr;
    assign b4.in_valid     = in_valid;
    assign b4.mode         = mode;
    assign b4.D1           = d1;
    assign b4.D2           = d2;
    assign b4.stall        = stall;
    assign b4.flush        = flush;
    assign b4.clear_count  = clr;

    pipelined_comparator #(.WIDTH(32), .CHUNK(4), .CW(16)) u16 (
        .clk(clk), .reset(reset), .bus(b16)
    );
    pipelined_comparator #(.WIDTH(32), .CHUNK(4), .CW(4)) u4 (
        .clk(clk), .reset(reset), .bus(b4)
    );

    // Reference result straight from the arithmetic meaning of each mode
    function automatic logic ref_z(input logic [2:0] m,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        case (m)
            EQ:      return a == b;
            NE:      return a != b;
            LT:      return $signed(a) < $signed(b);
            LTU:     return a < b;
            GE:      return $signed(a) >= $signed(b);
            GEU:     return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: one pending result and one visible result
    logic m_v1 = 1'b0;
    logic m_z1 = 1'b0;
    logic m_vo = 1'b0;
    logic m_zo = 1'b0;
    int   m_h16 = 0;
    int   m_h4 = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_v1  <= 1'b0;
            m_z1  <= 1'b0;
            m_vo  <= 1'b0;
            m_zo  <= 1'b0;
            m_h16 <= 0;
            m_h4  <= 0;
        end else begin
            if (flush) begin
                m_v1 <= 1'b0;
                m_vo <= 1'b0;
                m_zo <= 1'b0;
            end else if (!stall) begin
                m_v1 <= in_valid;
                m_z1 <= in_valid && ref_z(mode, d1, d2);
                m_vo <= m_v1;
                m_zo <= m_v1 && m_z1;
            end
            if (clr) begin
                m_h16 <= 0;
                m_h4  <= 0;
            end else if (!flush && !stall && m_v1 && m_z1) begin
                m_h16 <= (m_h16 < 65535) ? m_h16 + 1 : m_h16;
                m_h4  <= (m_h4 < 15) ? m_h4 + 1 : m_h4;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the reference
    always @(negedge clk) begin
        if (!reset) begin
            chk("ov16", 32'(b16.out_valid), 32'(m_vo));
            chk("z16", 32'(b16.Z), 32'(m_zo));
            chk("hit16", 32'(b16.hit_count), 32'(m_h16));
            chk("ov4", 32'(b4.out_valid), 32'(m_vo));
            chk("z4", 32'(b4.Z), 32'(m_zo));
            chk("hit4", 32'(b4.hit_count), 32'(m_h4));
        end
    end

    // Hand-computed expectations that also pin the reference
    task automatic lit(input string nm, input logic ov, input logic z,
                       input int h16, input int h4);
        chk({nm, ".ov"}, 32'(b16.out_valid), 32'(ov));
        chk({nm, ".z"}, 32'(b16.Z), 32'(z));
        chk({nm, ".h16"}, 32'(b16.hit_count), 32'(h16));
        chk({nm, ".ov4"}, 32'(b4.out_valid), 32'(ov));
        chk({nm, ".h4"}, 32'(b4.hit_count), 32'(h4));
        chk({nm, ".mdl"}, 32'({m_vo, m_zo}), 32'({ov, z}));
    endtask

    task automatic op(input logic [2:0] m, input logic [31:0] a,
                      input logic [31:0] b);
        in_valid = 1'b1;
        mode     = m;
        d1       = a;
        d2       = b;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lit("rst", 0, 0, 0, 0);
        reset = 1'b0;

        op(EQ, 32'hDEADBEEF, 32'hDEADBEEF);
        idle();
        lit("eq_dead", 1, 1, 1, 1);
        idle();
        lit("eq_gap", 0, 0, 1, 1);

        op(LT, 32'hFFFFFFFF, 32'h1);
        op(LTU, 32'hFFFFFFFF, 32'h1);
        lit("lt", 1, 1, 2, 2);
        op(GE, 32'hFFFFFFFF, 32'h1);
        lit("ltu", 1, 0, 2, 2);
        op(GEU, 32'hFFFFFFFF, 32'h1);
        lit("ge", 1, 0, 2, 2);
        idle();
        lit("geu", 1, 1, 3, 3);
        idle();
        lit("b2b_end", 0, 0, 3, 3);

        op(NE, 32'h00010000, 32'h0);
        op(EQ, 32'h00010000, 32'h0);
        lit("ne", 1, 1, 4, 4);
        op(3'b111, 32'h00010000, 32'h00010000);
        lit("eq_diff", 1, 0, 4, 4);
        idle();
        lit("rsv", 1, 0, 4, 4);
        idle();

        op(EQ, 32'h5, 32'h5);
        op(GEU, 32'h1, 32'h2);
        lit("stall_a", 1, 1, 5, 5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op(EQ, 32'h9, 32'h9);
            lit("stall_hold", 1, 1, 5, 5);
        end
        stall = 1'b0;
        idle();
        lit("stall_b", 1, 0, 5, 5);
        idle();
        lit("stall_end", 0, 0, 5, 5);

        op(EQ, 32'h7, 32'h8);
        op(EQ, 32'h8, 32'h8);
        lit("fl_a", 1, 0, 5, 5);
        stall = 1'b1;
        flush = 1'b1;
        idle();
        lit("flush", 0, 0, 5, 5);
        stall = 1'b0;
        flush = 1'b0;
        idle();
        lit("flush_none", 0, 0, 5, 5);
        idle();

        flush = 1'b1;
        op(EQ, 32'h1, 32'h1);
        flush = 1'b0;
        idle();
        lit("flush_drop", 0, 0, 5, 5);
        idle();
        lit("flush_drop2", 0, 0, 5, 5);

        for (int i = 0; i < 17; i++) begin
            op(EQ, 32'(i * 3), 32'(i * 3));
        end
        idle();
        lit("sat", 1, 1, 22, 15);
        idle();

        op(EQ, 32'h3, 32'h3);
        clr = 1'b1;
        idle();
        lit("clr_match", 1, 1, 0, 0);
        clr = 1'b0;
        idle();

        op(EQ, 32'h4, 32'h4);
        idle();
        lit("clr_pre", 1, 1, 1, 1);
        stall = 1'b1;
        clr = 1'b1;
        idle();
        lit("clr_stall", 1, 1, 0, 0);
        stall = 1'b0;
        clr = 1'b0;
        idle();

        op(EQ, 32'h6, 32'h6);
        op(EQ, 32'h7, 32'h7);
        lit("pre_rst", 1, 1, 1, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 lit("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        lit("rst_drain", 0, 0, 0, 0);
        @(negedge clk);
        lit("rst_drain2", 0, 0, 0, 0);

        op(LTU, 32'h1, 32'h2);
        idle();
        lit("post_rst", 1, 1, 1, 1);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
